// File: rtl/life_pkg.sv
// life_pkg: board geometry and game_state encoding for the Life scheduler.
// Config macro LIFE_TORUS_EN (consumed in life_cell_next) selects a toroidal board.
package life_pkg;

  localparam int GRID_DIM = 8;
  localparam int CELLS    = GRID_DIM * GRID_DIM;
  localparam int IDX_W    = 6;

  typedef enum logic [1:0] {
    ST_PAUSE   = 2'b00,
    ST_PROGRAM = 2'b01,
    ST_RUN     = 2'b10,
    ST_COMPUTE = 2'b11
  } state_e;

endpackage

// File: rtl/life_cell_next.sv
// life_cell_next: B3/S23 next value of one cell, combinational.
// LIFE_TORUS_EN defined: neighbours wrap modulo 8; undefined: off-board is dead.
module life_cell_next
  import life_pkg::*;
(
  input  logic [CELLS-1:0] i_grid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_next
);

  logic [2:0] w_row, w_col;
  logic [2:0] w_rm, w_rp, w_cm, w_cp;
  logic       w_vrm, w_vrp, w_vcm, w_vcp;
  logic [7:0] w_nb;
  logic [3:0] w_cnt;
  logic       w_self;

  assign w_row = i_idx[5:3];
  assign w_col = i_idx[2:0];
  // 3-bit arithmetic wraps naturally; validity flags mask edges when flat
  assign w_rm  = w_row - 3'd1;
  assign w_rp  = w_row + 3'd1;
  assign w_cm  = w_col - 3'd1;
  assign w_cp  = w_col + 3'd1;

`ifdef LIFE_TORUS_EN
  assign w_vrm = 1'b1;
  assign w_vrp = 1'b1;
  assign w_vcm = 1'b1;
  assign w_vcp = 1'b1;
`else
  assign w_vrm = (w_row != 3'd0);
  assign w_vrp = (w_row != 3'd7);
  assign w_vcm = (w_col != 3'd0);
  assign w_vcp = (w_col != 3'd7);
`endif

  assign w_self = i_grid[{w_row, w_col}];

  // gather the eight neighbours, masking off-board ones
  always_comb begin
    w_nb    = '0;
    w_nb[0] = i_grid[{w_rm, w_cm}] & w_vrm & w_vcm;
    w_nb[1] = i_grid[{w_rm, w_col}] & w_vrm;
    w_nb[2] = i_grid[{w_rm, w_cp}] & w_vrm & w_vcp;
    w_nb[3] = i_grid[{w_row, w_cm}] & w_vcm;
    w_nb[4] = i_grid[{w_row, w_cp}] & w_vcp;
    w_nb[5] = i_grid[{w_rp, w_cm}] & w_vrp & w_vcm;
    w_nb[6] = i_grid[{w_rp, w_col}] & w_vrp;
    w_nb[7] = i_grid[{w_rp, w_cp}] & w_vrp & w_vcp;
  end

  // population count of live neighbours
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      w_cnt = w_cnt + {3'b000, w_nb[k]};
    end
  end

  assign o_next = (w_cnt == 4'd3) | (w_self & (w_cnt == 4'd2));

endmodule

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: PAUSE/PROGRAM/RUN/COMPUTE control of an 8x8 Life board.
// Build option LIFE_TORUS_EN selects toroidal neighbour wrap in life_cell_next.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             prgm,
  input  logic             pp,
  input  logic             step,
  input  logic             btn0,
  input  logic             btn1,
  output logic [1:0]       game_state,
  output logic [CELLS-1:0] grid,
  output logic [IDX_W-1:0] cursor,
  output logic [15:0]      gen_count,
  output logic             still
);

  state_e              r_state, r_ret;
  state_e              w_state_nx, w_start_ret;
  logic                w_start, w_commit, w_prog;
  logic [CELLS-1:0]    r_grid;
  logic [CELLS-2:0]    r_acc;
  logic [CELLS-1:0]    w_new;
  logic [IDX_W-1:0]    r_cursor, r_idx;
  logic [15:0]         r_gen;
  logic                r_still, r_pend;
  logic [31:0]         r_presc;
  logic                w_cell;

  // r_grid is frozen during COMPUTE, so it is the entry snapshot
  life_cell_next u_cell (
    .i_grid (r_grid),
    .i_idx  (r_idx),
    .o_next (w_cell)
  );

  // cells 0..62 shift in LSB-first; cell 63 joins at the commit edge
  assign w_new = {w_cell, r_acc};

  // next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nx  = r_state;
    w_start     = 1'b0;
    w_start_ret = ST_PAUSE;
    w_commit    = 1'b0;
    w_prog      = 1'b0;
    unique case (r_state)
      ST_PAUSE: begin
        if (prgm) begin
          w_state_nx = ST_PROGRAM;
        end else if (pp) begin
          w_state_nx = ST_RUN;
        end else if (step) begin
          w_state_nx  = ST_COMPUTE;
          w_start     = 1'b1;
          w_start_ret = ST_PAUSE;
        end
      end
      ST_PROGRAM: begin
        w_prog = 1'b1;
        if (!prgm) w_state_nx = ST_PAUSE;
      end
      ST_RUN: begin
        if (prgm) begin
          w_state_nx = ST_PROGRAM;
        end else if (pp) begin
          w_state_nx = ST_PAUSE;
        end else if (r_presc == 32'(TICK_DIV - 1)) begin
          w_state_nx  = ST_COMPUTE;
          w_start     = 1'b1;
          w_start_ret = ST_RUN;
        end
      end
      ST_COMPUTE: begin
        if (r_idx == IDX_W'(CELLS - 1)) begin
          w_commit   = 1'b1;
          w_state_nx = (r_pend | pp) ? ST_PAUSE : r_ret;
        end
      end
      default: w_state_nx = ST_PAUSE;
    endcase
  end

  // state register
  always_ff @(posedge clka) begin
    if (rst) r_state <= ST_PAUSE;
    else     r_state <= w_state_nx;
  end

  // board, cursor, prescaler and generation bookkeeping
  always_ff @(posedge clka) begin
    if (rst) begin
      r_grid   <= '0;
      r_acc    <= '0;
      r_cursor <= '0;
      r_idx    <= '0;
      r_gen    <= '0;
      r_still  <= 1'b0;
      r_pend   <= 1'b0;
      r_presc  <= '0;
      r_ret    <= ST_PAUSE;
    end else begin
      if (r_state == ST_RUN && w_state_nx == ST_RUN)
        r_presc <= r_presc + 32'd1;
      else
        r_presc <= '0;

      if (w_prog) begin
        if (btn1) begin
          r_grid[r_cursor] <= ~r_grid[r_cursor];
          r_still          <= 1'b0;
        end
        if (btn0) r_cursor <= r_cursor + IDX_W'(1);
      end

      if (w_start) begin
        r_idx  <= '0;
        r_pend <= 1'b0;
        r_ret  <= w_start_ret;
      end

      if (r_state == ST_COMPUTE) begin
        r_acc <= {w_cell, r_acc[CELLS-2:1]};
        r_idx <= r_idx + IDX_W'(1);
        if (pp) r_pend <= 1'b1;
        if (w_commit) begin
          r_grid  <= w_new;
          r_gen   <= r_gen + 16'd1;
          r_still <= (w_new == r_grid);
          r_pend  <= 1'b0;
        end
      end
    end
  end

  assign game_state = r_state;
  assign grid       = r_grid;
  assign cursor     = r_cursor;
  assign gen_count  = r_gen;
  assign still      = r_still;

endmodule
